// File: rtl/paddle_if.sv
// Bus between the paddle controller and its consumer: the keycode input and the paddle outputs.
// There is no handshake. keycode is a level signal. The controller samples it once per frame tick, and the outputs are registered levels.
interface paddle_if;
    logic [15:0]       keycode;
    logic [9:0]        PaddleX;
    logic [9:0]        PaddleY;
    logic [9:0]        Paddle_size;
    logic signed [4:0] Paddle_vel;
    logic [1:0]        state_dbg;

    modport master (
        output keycode,
        input  PaddleX, PaddleY, Paddle_size, Paddle_vel, state_dbg
    );
    modport slave (
        input  keycode,
        output PaddleX, PaddleY, Paddle_size, Paddle_vel, state_dbg
    );
endinterface

// File: rtl/paddle_motion.sv
// Per-frame paddle position controller with an accelerate/coast velocity model and edge clamping.
// Optional macro PADDLE_FRICTION_EN: when defined, released keys let the paddle coast to a stop.
module paddle_motion #(
    parameter int X_START   = 320,
    parameter int Y_POS     = 440,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int HALF_W    = 24,
    parameter int SIZE      = 6,
    parameter int MAX_SPEED = 8,
    parameter int ACCEL     = 1
) (
    input  logic     Clk,
    input  logic     Reset,
    input  logic     frame_clk,
    paddle_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCEL_L = 2'd1, ACCEL_R = 2'd2, COAST = 2'd3} state_e;

    localparam logic signed [10:0] X_LO = 11'(X_MIN + HALF_W);
    localparam logic signed [10:0] X_HI = 11'(X_MAX - HALF_W);
    localparam logic signed [6:0]  ACC7 = 7'(ACCEL);
    localparam logic signed [6:0]  MAX7 = 7'(MAX_SPEED);

    logic              sync1_q, sync2_q, dly_q;
    logic [1:0]        fill_q;
    logic              armed_q, armed_d;
    state_e            state_q, state_d;
    logic signed [4:0] vel_q, vel_d;
    logic [9:0]        x_q, x_d;
    logic              tick, key_l, key_r;
    logic signed [6:0] v_step;
    logic signed [10:0] nx;

    // Edge detection arms only after the synchronizer has seen frame_clk low.
    // A frame_clk held high across reset therefore cannot produce a tick.
    assign armed_d = armed_q | (fill_q[1] & ~sync2_q);
    assign tick    = sync2_q & ~dly_q & armed_q;
    assign key_l   = (bus.keycode[7:0] == 8'h04) || (bus.keycode[15:8] == 8'h04);
    assign key_r   = (bus.keycode[7:0] == 8'h07) || (bus.keycode[15:8] == 8'h07);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
            state_q <= IDLE;
            vel_q   <= '0;
            x_q     <= 10'(X_START);
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_d;
            state_q <= state_d;
            vel_q   <= vel_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vel_d   = vel_q;
        x_d     = x_q;
        v_step  = 7'(vel_q);
        nx      = '0;
        if (tick) begin
            if (key_l && !key_r) begin
                state_d = ACCEL_L;
                v_step  = 7'(vel_q) - ACC7;
                if (v_step < -MAX7) v_step = -MAX7;
            end else if (key_r && !key_l) begin
                state_d = ACCEL_R;
                v_step  = 7'(vel_q) + ACC7;
                if (v_step > MAX7) v_step = MAX7;
            end else begin
`ifdef PADDLE_FRICTION_EN
                if (vel_q > 5'sd0)      v_step = 7'(vel_q) - 7'sd1;
                else if (vel_q < 5'sd0) v_step = 7'(vel_q) + 7'sd1;
                else                    v_step = 7'sd0;
                state_d = (v_step != 7'sd0) ? COAST : IDLE;
`else
                v_step  = 7'sd0;
                state_d = IDLE;
`endif
            end
            // PaddleX is an unsigned screen column, so it is zero-extended. The velocity is sign-extended.
            nx = $signed({1'b0, x_q}) + 11'(v_step);
            if (nx < X_LO) begin
                x_d     = 10'(X_LO);
                vel_d   = '0;
                state_d = IDLE;
            end else if (nx > X_HI) begin
                x_d     = 10'(X_HI);
                vel_d   = '0;
                state_d = IDLE;
            end else begin
                x_d   = nx[9:0];
                vel_d = v_step[4:0];
            end
        end
    end

    assign bus.PaddleX     = x_q;
    assign bus.PaddleY     = 10'(Y_POS);
    assign bus.Paddle_size = 10'(SIZE);
    assign bus.Paddle_vel  = vel_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_paddle_motion.sv
// Self-checking bench for paddle_motion: directed frames from the test plan, then randomized keycodes.
// The reference model applies the velocity and clamp rules with plain integer arithmetic.
module tb_paddle_motion;
    localparam int ST_I = 0, ST_L = 1, ST_R = 2, ST_C = 3;
    localparam int LO = 0 + 24, HI = 639 - 24;

    logic Clk, Reset, frame_clk;
    paddle_if bus ();

    paddle_motion dut (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .bus(bus));

    int errors = 0;
    int checks = 0;
    int m_x, m_v, m_st;
    bit m_clamped;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 320; m_v = 0; m_st = ST_I; m_clamped = 0;
    endtask

    task automatic model_step(input logic [15:0] k);
        bit l, r;
        int nx;
        l = (k[7:0] == 8'h04) || (k[15:8] == 8'h04);
        r = (k[7:0] == 8'h07) || (k[15:8] == 8'h07);
        if (l && !r) begin
            m_v = (m_v - 1 < -8) ? -8 : m_v - 1; m_st = ST_L;
        end else if (r && !l) begin
            m_v = (m_v + 1 > 8) ? 8 : m_v + 1; m_st = ST_R;
        end else begin
`ifdef PADDLE_FRICTION_EN
            if (m_v > 0) m_v--; else if (m_v < 0) m_v++;
            m_st = (m_v != 0) ? ST_C : ST_I;
`else
            m_v = 0; m_st = ST_I;
`endif
        end
        nx = m_x + m_v;
        m_clamped = 0;
        if (nx < LO) begin
            m_x = LO; m_v = 0; m_st = ST_I; m_clamped = 1;
        end else if (nx > HI) begin
            m_x = HI; m_v = 0; m_st = ST_I; m_clamped = 1;
        end else begin
            m_x = nx;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_x"}, bus.PaddleX, m_x);
        chk({tag, "_v"}, bus.Paddle_vel, m_v);
        chk({tag, "_st"}, bus.state_dbg, m_st);
        chk({tag, "_y"}, bus.PaddleY, 440);
        chk({tag, "_sz"}, bus.Paddle_size, 6);
    endtask

    // One frame: raise frame_clk between edges, expect the update on the third edge after it.
    task automatic run_frame(input logic [15:0] k, input string tag);
        @(posedge Clk); #2;
        bus.keycode = k;
        frame_clk = 1'b1;
        @(posedge Clk);
        @(posedge Clk); #1;
        chk({tag, "_hold_x"}, bus.PaddleX, m_x);
        chk({tag, "_hold_v"}, bus.Paddle_vel, m_v);
        model_step(k);
        @(posedge Clk); #1;
        check_all(tag);
        bus.keycode = 16'($urandom());
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
    endtask

    task automatic apply_reset();
        @(posedge Clk); #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check_all("rst");
        repeat (2) @(posedge Clk);
        #2 Reset = 1'b0;
        repeat (4) @(posedge Clk);
    endtask

    logic [15:0] key_tab [6];
    logic [15:0] k;
    int idx;

    initial begin
        key_tab = '{16'h0000, 16'h0004, 16'h0007, 16'h0407, 16'h0400, 16'h0700};
        Reset = 1'b1;
        frame_clk = 1'b0;
        bus.keycode = 16'h0000;
        model_reset();
        #1;
        check_all("por");
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;
        repeat (4) @(posedge Clk);

        for (int i = 0; i < 3; i++) run_frame(16'h0000, "idle");
        chk("idle_x320", bus.PaddleX, 320);

        for (int i = 0; i < 10; i++) run_frame(16'h0007, "right");
        chk("right_x372", bus.PaddleX, 372);
        chk("right_v8", bus.Paddle_vel, 8);

        for (int i = 0; i < 9; i++) begin
            run_frame(16'h0400, "left_hi");
            chk("left_hi_st", bus.state_dbg, ST_L);
        end
        chk("left_x399", bus.PaddleX, 399);
        chk("left_vm1", bus.Paddle_vel, -1);

        for (int i = 0; i < 100 && !m_clamped; i++) run_frame(16'h0007, "to_edge");
        chk("clamp_x615", bus.PaddleX, 615);
        chk("clamp_v0", bus.Paddle_vel, 0);
        run_frame(16'h0007, "reclamp");
        chk("reclamp_x615", bus.PaddleX, 615);

        apply_reset();
        for (int i = 0; i < 5; i++) run_frame(16'h0007, "v5");
        chk("v5_v", bus.Paddle_vel, 5);
        chk("v5_x", bus.PaddleX, 335);
`ifdef PADDLE_FRICTION_EN
        for (int i = 0; i < 5; i++) run_frame(16'h0000, "glide");
        chk("glide_x345", bus.PaddleX, 345);
`else
        run_frame(16'h0000, "stop");
        chk("stop_x335", bus.PaddleX, 335);
`endif
        chk("release_v0", bus.Paddle_vel, 0);

        for (int i = 0; i < 60; i++) begin
            idx = $urandom_range(0, 6);
            k = (idx == 6) ? 16'($urandom()) : key_tab[idx];
            run_frame(k, "rand");
        end

        for (int i = 0; i < 4; i++) run_frame(16'h0007, "pre_rst");
        @(posedge Clk); #2;
        frame_clk = 1'b1;
        @(posedge Clk); #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check_all("mid_rst");
        @(posedge Clk); #2;
        Reset = 1'b0;
        bus.keycode = 16'h0007;
        repeat (8) @(posedge Clk); #1;
        check_all("no_tick");
        frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        run_frame(16'h0007, "post_rst");
        chk("post_rst_x321", bus.PaddleX, 321);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
